// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg
// Shared types and helpers for the system-clock half of the CPU debug slave.
//   cmd_t    : command layout at the default widths (ir, data, optional par).
//              The top builds the same packed layout at its parameter widths.
//   ptr_w()  : FIFO pointer width for a given depth (index bits + wrap bit).
//   even_par(): even-parity bit over a zero-extended vector.
// Optional feature macro: DEBUG_CMD_PARITY_EN (adds the par field).
package debug_cmd_pkg;

  localparam int CMD_IR_W  = 2;
  localparam int CMD_SR_W  = 38;
  // Widest {ir, sr} vector the parity helper accepts.
  localparam int PAR_MAX_W = 1024;

  typedef struct packed {
    logic [CMD_IR_W-1:0] ir;
    logic [CMD_SR_W-1:0] data;
`ifdef DEBUG_CMD_PARITY_EN
    logic                par;
`endif
  } cmd_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Bit that makes the total number of ones (vector + bit) even.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// debug_cmd_fifo
// Synchronous FIFO with simultaneous push/pop. Pointers carry one extra wrap
// bit: equal pointers mean empty; equal index bits with differing wrap bits
// mean full. A push while full is accepted only when a pop happens in the
// same cycle. full/empty are registered from the next-state pointers.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties FIFO)
//   push, din       : write request and data
//   pop             : read request (ignored while empty)
//   dout            : head entry
//   full, empty     : registered status
module debug_cmd_fifo
  import debug_cmd_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             full_reg, full_next;
  logic             empty_reg, empty_next;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_reg;
  // A pop frees the slot in the same edge, so full does not block the push.
  assign do_push = push && (!full_reg || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    empty_next = (wr_ptr_next == rd_ptr_next);
    full_next  = (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]) &&
                 (wr_ptr_next[PTR_W-1] != rd_ptr_next[PTR_W-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[IDX_W-1:0]] <= din;
  end

  assign dout  = mem_reg[rd_ptr_reg[IDX_W-1:0]];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/debug_cmd_sync.sv
// debug_cmd_sync
// System-clock half of the CPU debug slave. Synchronises the TCK-domain
// update-IR / update-DR levels into clk, queues {ir_in, sr} on each
// update-DR rising edge and hands commands to the CPU debug logic over a
// valid/ready handshake with decoded take_action / take_no_action pulses.
// Optional feature macro: DEBUG_CMD_PARITY_EN (per-entry even parity and
// cmd_perr reporting; when undefined cmd_perr is tied low).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   vs_udr, vs_uir          : asynchronous update-DR / update-IR levels
//   ir_in, sr               : instruction and scanned data register
//   cmd_valid, cmd_ready    : head handshake
//   cmd_ir, jdo             : head instruction / data
//   take_action             : one-hot pulse on accept with action bit set
//   take_no_action          : one-hot pulse on accept with action bit clear
//   ir_update, cur_ir       : update-IR pulse and latched instruction
//   ovf, ovf_clr            : sticky dropped-command flag and its clear
//   cmd_perr                : head parity mismatch
module debug_cmd_sync
  import debug_cmd_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [SR_W-1:0]      sr,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [SR_W-1:0]      jdo,
  output logic [(2**IR_W)-1:0] take_action,
  output logic [(2**IR_W)-1:0] take_no_action,
  output logic                 ir_update,
  output logic [IR_W-1:0]      cur_ir,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 cmd_perr
);

  localparam int NCH   = 2**IR_W;
  localparam int CMD_W = IR_W + SR_W;
`ifdef DEBUG_CMD_PARITY_EN
  localparam int E_W = CMD_W + 1;
`else
  localparam int E_W = CMD_W;
`endif

  // ---------------------------------------------------------------------
  // Strobe synchronisers: index 0 = update-DR, index 1 = update-IR.
  // ---------------------------------------------------------------------
  logic [1:0]             strobe;
  logic [1:0]             rise;
  logic [SYNC_STAGES-1:0] fill_reg;

  assign strobe = {vs_uir, vs_udr};

  // fill_reg tracks when the synchroniser outputs carry real samples again
  // after reset, so the cleared chain is not mistaken for a low level.
  always_ff @(posedge clk) begin
    if (reset) fill_reg <= '0;
    else       fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   armed_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_reg  <= '0;
        prev_reg  <= 1'b0;
        armed_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], strobe[gi]};
        prev_reg <= sync_reg[SYNC_STAGES-1];
        // A strobe high at reset release must be seen low before its next
        // rise counts.
        if (fill_reg[SYNC_STAGES-1] && !sync_reg[SYNC_STAGES-1])
          armed_reg <= 1'b1;
      end
    end

    assign rise[gi] = armed_reg && sync_reg[SYNC_STAGES-1] && !prev_reg;
  end

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [E_W-1:0]   push_data;
  logic [E_W-1:0]   head;
  logic [CMD_W-1:0] head_cmd;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;

`ifdef DEBUG_CMD_PARITY_EN
  assign push_data = {ir_in, sr, even_par(PAR_MAX_W'({ir_in, sr}))};
  assign head_cmd  = head[E_W-1:1];
  assign cmd_perr  = cmd_valid && (head[0] != even_par(PAR_MAX_W'(head_cmd)));
`else
  assign push_data = {ir_in, sr};
  assign head_cmd  = head;
  assign cmd_perr  = 1'b0;
`endif

  assign cmd_valid = !fifo_empty;
  assign pop       = cmd_valid && cmd_ready;
  assign push      = rise[0];
  assign drop      = push && fifo_full && !pop;

  debug_cmd_fifo #(
    .W     (E_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {cmd_ir, jdo} = head_cmd;

  // One-hot decode of the accepted head, split by the action bit.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_take
    assign take_action[gi]    = pop && (cmd_ir == IR_W'(gi)) &&  jdo[SR_W-1];
    assign take_no_action[gi] = pop && (cmd_ir == IR_W'(gi)) && !jdo[SR_W-1];
  end

  // ---------------------------------------------------------------------
  // Update-IR pulse, current instruction and overflow flag
  // ---------------------------------------------------------------------
  logic            ir_update_reg;
  logic [IR_W-1:0] cur_ir_reg;
  logic            ovf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_update_reg <= 1'b0;
      cur_ir_reg    <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      ir_update_reg <= rise[1];
      if (rise[1]) cur_ir_reg <= ir_in;
      // A drop in the same cycle as a clear wins.
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign ir_update = ir_update_reg;
  assign cur_ir    = cur_ir_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_debug_cmd_sync.sv
module tb_debug_cmd_sync;
  import debug_cmd_pkg::*;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int NCH   = 4;
  localparam int CW    = IR_W + SR_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            vs_udr, vs_uir;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            cmd_valid, cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action, take_no_action;
  logic            ir_update;
  logic [IR_W-1:0] cur_ir;
  logic            ovf, ovf_clr, cmd_perr;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued commands in arrival order and the sticky flag.
  logic [CW-1:0] model_q[$];
  logic          model_ovf;

  always #5 clk = ~clk;

  debug_cmd_sync #(
    .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(S), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .ir_update(ir_update), .cur_ir(cur_ir),
    .ovf(ovf), .ovf_clr(ovf_clr), .cmd_perr(cmd_perr)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (S + 4) @(posedge clk);
    #1;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  // Scan one command with cmd_ready low; updates the model afterwards.
  task automatic udr_pulse(input logic [IR_W-1:0] p_ir, input logic [SR_W-1:0] p_sr,
                           input int hold);
    ir_in = p_ir; sr = p_sr; vs_udr = 1'b1;
    repeat (hold) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    if (model_q.size() < DEPTH) model_q.push_back({p_ir, p_sr});
    else                        model_ovf = 1'b1;
    $display("push ir=%0d data=%h queued=%0d ovf_exp=%0b", p_ir, p_sr, model_q.size(), model_ovf);
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    return SR_W'({$urandom, $urandom});
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (cur_ir !== '0) begin failures++; $display("FAIL reset_cur_ir got=%0d exp=0", cur_ir); end
    checks++; if (ir_update !== 1'b0) begin failures++; $display("FAIL reset_ir_update got=%b exp=0", ir_update); end
    checks++; if (take_action !== '0 || take_no_action !== '0) begin failures++; $display("FAIL reset_take got=%b/%b exp=0/0", take_action, take_no_action); end
    checks++; if (cmd_perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", cmd_perr); end
    $display("reset checked");
  endtask

  task automatic test_latency();
    int first, pulses;
    logic [SR_W-1:0] v;
    do_reset();
    cmd_ready = 1'b1;
    v = rand_sr(); v[SR_W-1] = 1'b1;
    ir_in = 2'd2; sr = v; vs_udr = 1'b1;   // next posedge is E0
    first = -1; pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (take_action !== '0 || take_no_action !== '0) begin
        pulses++;
        if (first < 0) first = k;
        checks++; if (take_action !== 4'b0100 || take_no_action !== 4'b0000) begin failures++; $display("FAIL lat_take got=%b/%b exp=0100/0000", take_action, take_no_action); end
        checks++; if (jdo !== v) begin failures++; $display("FAIL lat_jdo got=%h exp=%h", jdo, v); end
      end
      if (k == 3) vs_udr = 1'b0;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL lat_pulse_count got=%0d exp=1", pulses); end
    checks++; if (first !== S) begin failures++; $display("FAIL lat_cycle got=%0d exp=%0d", first, S); end
    $display("latency pulse at E0+%0d count=%0d", first, pulses);
    cmd_ready = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_drain();
    logic [CW-1:0]    e;
    logic [NCH-1:0]   ea, en;
    logic [IR_W-1:0]  eir;
    for (int n = 0; n < 64; n++) begin
      if (model_q.size() == 0) break;
      @(negedge clk); cmd_ready = 1'b1; #1;
      e = model_q.pop_front();
      eir = e[CW-1:SR_W];
      ea = '0; en = '0;
      if (e[SR_W-1]) ea[eir] = 1'b1; else en[eir] = 1'b1;
      checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid got=%b exp=1", cmd_valid); end
      checks++; if (cmd_ir !== eir || jdo !== e[SR_W-1:0]) begin failures++; $display("FAIL drain_head got=%0d/%h exp=%0d/%h", cmd_ir, jdo, eir, e[SR_W-1:0]); end
      checks++; if (take_action !== ea || take_no_action !== en) begin failures++; $display("FAIL drain_take got=%b/%b exp=%b/%b", take_action, take_no_action, ea, en); end
      $display("pop ir=%0d data=%h act=%b noact=%b", cmd_ir, jdo, take_action, take_no_action);
      @(posedge clk);
    end
    @(negedge clk); cmd_ready = 1'b0; #1;
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", cmd_valid); end
    cmd_ready = 1'b1; #1;
    checks++; if (take_action !== '0 || take_no_action !== '0) begin failures++; $display("FAIL drain_take_empty got=%b/%b exp=0/0", take_action, take_no_action); end
    cmd_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      udr_pulse(IR_W'($urandom), rand_sr(), $urandom_range(1, 4));
      checks++; if (ovf !== model_ovf) begin failures++; $display("FAIL ovf_step%0d got=%b exp=%b", i, ovf, model_ovf); end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_after_five got=%b exp=1", ovf); end
    ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0;
    model_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    $display("overflow cleared, draining %0d", model_q.size());
  endtask

  task automatic test_full_pop();
    logic [CW-1:0]   e;
    logic [NCH-1:0]  ea, en;
    logic [IR_W-1:0] nir;
    logic [SR_W-1:0] nsr;
    do_reset();
    for (int i = 0; i < DEPTH; i++) udr_pulse(IR_W'($urandom), rand_sr(), 2);
    nir = IR_W'($urandom); nsr = rand_sr();
    ir_in = nir; sr = nsr; vs_udr = 1'b1;   // next posedge is E0
    for (int k = 0; k < S + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) vs_udr = 1'b0;
      cmd_ready = (k == S - 1);
      if (k == S - 1) begin
        #1;
        e = model_q[0];
        ea = '0; en = '0;
        if (e[SR_W-1]) ea[e[CW-1:SR_W]] = 1'b1; else en[e[CW-1:SR_W]] = 1'b1;
        checks++; if (take_action !== ea || take_no_action !== en) begin failures++; $display("FAIL fullpop_take got=%b/%b exp=%b/%b", take_action, take_no_action, ea, en); end
      end
    end
    cmd_ready = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back({nir, nsr});
    repeat (S + 3) @(posedge clk);
    #1;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%b exp=0", ovf); end
    $display("full push+pop ir=%0d data=%h queued=%0d", nir, nsr, model_q.size());
  endtask

  task automatic test_ir_update();
    logic [IR_W-1:0] v;
    int cnt;
    do_reset();
    udr_pulse(IR_W'($urandom), rand_sr(), 1);
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 2'd3 : IR_W'($urandom);
      ir_in = v; vs_uir = 1'b1; cnt = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); @(negedge clk);
        if (ir_update === 1'b1) cnt++;
        if (k == 1) vs_uir = 1'b0;
      end
      checks++; if (cnt !== 1) begin failures++; $display("FAIL iru_pulses got=%0d exp=1", cnt); end
      checks++; if (cur_ir !== v) begin failures++; $display("FAIL iru_cur_ir got=%0d exp=%0d", cur_ir, v); end
      checks++; if (cmd_valid !== 1'b1 || jdo !== model_q[0][SR_W-1:0]) begin failures++; $display("FAIL iru_fifo got=%b/%h exp=1/%h", cmd_valid, jdo, model_q[0][SR_W-1:0]); end
      $display("ir_update ir=%0d pulses=%0d", v, cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    for (int i = 0; i < 3; i++) udr_pulse(IR_W'($urandom), rand_sr(), 2);
    vs_udr = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", cmd_valid); end
    reset = 1'b0;
    model_q.delete(); model_ovf = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_held_push got=%0d exp=0 valid cycles", bad); end
    vs_udr = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    udr_pulse(IR_W'($urandom), rand_sr(), 3);
    checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL rstmid_repush got=%b exp=1", cmd_valid); end
  endtask

  task automatic test_random();
    logic [CW-1:0]   e;
    logic [NCH-1:0]  ea, en;
    int r;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        udr_pulse(IR_W'($urandom), rand_sr(), $urandom_range(1, 4));
        checks++; if (ovf !== model_ovf) begin failures++; $display("FAIL rand_ovf got=%b exp=%b", ovf, model_ovf); end
      end else if (r < 8) begin
        @(negedge clk); cmd_ready = 1'b1; #1;
        if (model_q.size() != 0) begin
          e = model_q.pop_front();
          ea = '0; en = '0;
          if (e[SR_W-1]) ea[e[CW-1:SR_W]] = 1'b1; else en[e[CW-1:SR_W]] = 1'b1;
          checks++; if (cmd_valid !== 1'b1 || cmd_ir !== e[CW-1:SR_W] || jdo !== e[SR_W-1:0]) begin failures++; $display("FAIL rand_head got=%b/%0d/%h exp=1/%0d/%h", cmd_valid, cmd_ir, jdo, e[CW-1:SR_W], e[SR_W-1:0]); end
          checks++; if (take_action !== ea || take_no_action !== en) begin failures++; $display("FAIL rand_take got=%b/%b exp=%b/%b", take_action, take_no_action, ea, en); end
          $display("pop ir=%0d data=%h", cmd_ir, jdo);
        end else begin
          checks++; if (cmd_valid !== 1'b0 || take_action !== '0 || take_no_action !== '0) begin failures++; $display("FAIL rand_empty got=%b/%b/%b exp=0/0/0", cmd_valid, take_action, take_no_action); end
          $display("pop on empty queue");
        end
        @(posedge clk); #1 cmd_ready = 1'b0;
      end else begin
        ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0;
        model_ovf = 1'b0;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rand_ovf_clr got=%b exp=0", ovf); end
        $display("ovf_clr");
      end
    end
  endtask

`ifdef DEBUG_CMD_PARITY_EN
  task automatic test_parity();
    do_reset();
    udr_pulse(IR_W'($urandom), rand_sr(), 2);
    udr_pulse(IR_W'($urandom), rand_sr(), 2);
    checks++; if (cmd_perr !== 1'b0) begin failures++; $display("FAIL par_clean got=%b exp=0", cmd_perr); end
    dut.u_fifo.mem_reg[1][0] = ~dut.u_fifo.mem_reg[1][0];
    #1;
    checks++; if (cmd_perr !== 1'b0) begin failures++; $display("FAIL par_head0 got=%b exp=0", cmd_perr); end
    @(negedge clk); cmd_ready = 1'b1; @(posedge clk); #1 cmd_ready = 1'b0;
    void'(model_q.pop_front());
    checks++; if (cmd_perr !== 1'b1) begin failures++; $display("FAIL par_head1 got=%b exp=1", cmd_perr); end
    cmd_ready = 1'b1; #1;
    checks++; if ((take_action | take_no_action) === '0) begin failures++; $display("FAIL par_take got=%b/%b exp=nonzero", take_action, take_no_action); end
    @(posedge clk); #1 cmd_ready = 1'b0;
    void'(model_q.pop_front());
    checks++; if (cmd_perr !== 1'b0) begin failures++; $display("FAIL par_empty got=%b exp=0", cmd_perr); end
    $display("parity error injected on second entry");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_drain();
    test_full_pop();
    test_drain();
    test_ir_update();
    test_drain();
    test_reset_mid();
    test_drain();
    test_random();
    test_drain();
`ifdef DEBUG_CMD_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
